// File: rtl/sampling_ctrl_pkg.sv
// Shared constants and state encoding for the 2x2 sampling-layer controller.
package sampling_ctrl_pkg;

  // Default feature-map geometry and drain watchdog length.
  localparam int IMG_W_DEF   = 10;
  localparam int IMG_H_DEF   = 10;
  localparam int TIMEOUT_DEF = 255;

  // Number of pooled outputs one feature map produces.
  localparam int OUT_COUNT   = (IMG_W_DEF / 2) * (IMG_H_DEF / 2);

  // Address widths of the input (raster) and output (pooled) buffers.
  localparam int RD_ADDR_W   = 7;
  localparam int WR_ADDR_W   = 5;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_FEED  = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/sampling_layer2_controller.sv
// Sequencer for the 2x2 sampling layer: streams one raster feature map out of
// the input buffer, writes the pooled results into the output buffer and
// flags any protocol fault. Pixel data does not pass through this block.
module sampling_layer2_controller
  import sampling_ctrl_pkg::*;
#(
  parameter int IMG_W   = IMG_W_DEF,
  parameter int IMG_H   = IMG_H_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_start,
  input  logic                 i_hold,
  output logic                 o_rd_en,
  output logic [RD_ADDR_W-1:0] o_rd_addr,
  output logic                 o_layer_reset,
  output logic                 o_layer_valid,
  output logic                 o_layer_finish,
  input  logic                 i_layer_out_valid,
  input  logic                 i_layer_out_finish,
  output logic                 o_wr_en,
  output logic [WR_ADDR_W-1:0] o_wr_addr,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_error
);

  localparam int N_PIX    = IMG_W * IMG_H;
  localparam int N_OUT    = (IMG_W / 2) * (IMG_H / 2);
  localparam int RD_CNT_W = RD_ADDR_W + 1;
  localparam int WR_CNT_W = WR_ADDR_W + 1;
  localparam int IDLE_W   = $clog2(TIMEOUT + 1);

  state_t              r_state;
  state_t              w_next_state;
  logic [RD_CNT_W-1:0] r_rd_cnt;
  logic [WR_CNT_W-1:0] r_wr_cnt;
  logic [IDLE_W-1:0]   r_idle_cnt;
  logic                r_error;
  logic                r_layer_valid;
  logic                r_layer_finish;

  logic                w_rd_en;
  logic                w_rd_last;
  logic                w_wr_en;
  logic                w_err_set;
  logic [WR_CNT_W-1:0] w_wr_cnt_next;

  assign w_rd_last     = (r_rd_cnt == RD_CNT_W'(N_PIX - 1));
  assign w_wr_cnt_next = r_wr_cnt + WR_CNT_W'(w_wr_en);

  // Next-state, read/write strobes and fault detection.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    w_next_state = r_state;
    w_rd_en      = 1'b0;
    w_wr_en      = 1'b0;
    w_err_set    = 1'b0;

    // Layer results are accepted only while a map is in flight; a result
    // beyond the last output slot is dropped and flagged.
    if ((r_state == S_FEED || r_state == S_DRAIN) && i_layer_out_valid) begin
      if (r_wr_cnt == WR_CNT_W'(N_OUT)) begin
        w_err_set = 1'b1;
      end else begin
        w_wr_en = 1'b1;
      end
    end

    case (r_state)
      S_IDLE: begin
        if (i_start) w_next_state = S_CLEAR;
      end
      S_CLEAR: begin
        w_next_state = S_FEED;
      end
      S_FEED: begin
        if (!i_hold) begin
          w_rd_en = 1'b1;
          if (w_rd_last) w_next_state = S_DRAIN;
        end
        // The layer cannot legitimately finish before it has seen every pixel.
        if (i_layer_out_finish) w_err_set = 1'b1;
      end
      S_DRAIN: begin
        if (i_layer_out_finish) begin
          w_next_state = S_DONE;
          if (w_wr_cnt_next != WR_CNT_W'(N_OUT)) w_err_set = 1'b1;
        end else if (!i_layer_out_valid &&
                     r_idle_cnt == IDLE_W'(TIMEOUT - 2)) begin
          // The DONE cycle is the final silent cycle, so Done lands exactly
          // TIMEOUT cycles after the last layer output.
          w_err_set    = 1'b1;
          w_next_state = S_DONE;
        end
      end
      S_DONE: begin
        w_next_state = S_IDLE;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // State register, address counters, watchdog and sticky fault flag.
  always_ff @(posedge i_clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (i_reset) begin
      r_state    <= S_IDLE;
      r_rd_cnt   <= '0;
      r_wr_cnt   <= '0;
      r_idle_cnt <= '0;
      r_error    <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (r_state == S_CLEAR) begin
        r_rd_cnt   <= '0;
        r_wr_cnt   <= '0;
        r_idle_cnt <= '0;
        r_error    <= 1'b0;
      end else begin
        if (w_rd_en)   r_rd_cnt <= r_rd_cnt + RD_CNT_W'(1);
        if (w_wr_en)   r_wr_cnt <= w_wr_cnt_next;
        if (w_err_set) r_error  <= 1'b1;
        if (r_state == S_DRAIN && !i_layer_out_valid) begin
          r_idle_cnt <= r_idle_cnt + IDLE_W'(1);
        end else begin
          r_idle_cnt <= '0;
        end
      end
    end
  end

  // One-cycle delay matching the input buffer read latency.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_layer_valid  <= 1'b0;
      r_layer_finish <= 1'b0;
    end else begin
      r_layer_valid  <= w_rd_en;
      r_layer_finish <= w_rd_en && w_rd_last;
    end
  end

  // Outputs are forced quiet while reset is held; the layer is held in reset.
  assign o_rd_en        = w_rd_en & ~i_reset;
  assign o_rd_addr      = (w_rd_en && !i_reset) ? r_rd_cnt[RD_ADDR_W-1:0] : '0;
  assign o_layer_reset  = i_reset | (r_state == S_CLEAR);
  assign o_layer_valid  = r_layer_valid & ~i_reset;
  assign o_layer_finish = r_layer_finish & ~i_reset;
  assign o_wr_en        = w_wr_en & ~i_reset;
  assign o_wr_addr      = (w_wr_en && !i_reset) ? r_wr_cnt[WR_ADDR_W-1:0] : '0;
  assign o_busy         = (r_state != S_IDLE) & ~i_reset;
  assign o_done         = (r_state == S_DONE) & ~i_reset;
  assign o_error        = r_error & ~i_reset;

endmodule

// File: tb/tb_sampling_layer2_controller.sv
// Directed bench for sampling_layer2_controller: a vector table for the
// opening cycles plus scripted whole-map runs with a simple layer model.
module tb_sampling_layer2_controller;
  import sampling_ctrl_pkg::*;

  localparam int N_PIX = 100;
  localparam int N_OUT = 25;
  localparam int TMO   = 255;

  logic       clk = 1'b0;
  logic       reset, start, hold, lov, lof;
  logic       rd_en, layer_reset, layer_valid, layer_finish, wr_en;
  logic       busy, done, error;
  logic [6:0] rd_addr;
  logic [4:0] wr_addr;

  always #5 clk = ~clk;

  sampling_layer2_controller dut (
    .i_clk              (clk),
    .i_reset            (reset),
    .i_start            (start),
    .i_hold             (hold),
    .o_rd_en            (rd_en),
    .o_rd_addr          (rd_addr),
    .o_layer_reset      (layer_reset),
    .o_layer_valid      (layer_valid),
    .o_layer_finish     (layer_finish),
    .i_layer_out_valid  (lov),
    .i_layer_out_finish (lof),
    .o_wr_en            (wr_en),
    .o_wr_addr          (wr_addr),
    .o_busy             (busy),
    .o_done             (done),
    .o_error            (error)
  );

  int checks   = 0;
  int failures = 0;
  bit sticky_err = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    bit rst, st, hd, ov, of;
    int e_rd, e_addr, e_lr, e_lv, e_lf, e_wr, e_waddr, e_busy, e_done, e_err;
  } vec_t;

  vec_t tbl [12];

  // One full map. hold_addr/rst_addr < 0 disable those events. late: the
  // layer stays silent until DRAIN, gives 10 outputs and never finishes.
  // extra: one additional output in the first DRAIN cycle.
  task automatic run_frame(input string tag, input int n_out, input int hold_addr,
                           input int hold_len, input bit late, input bit extra,
                           input bit start_mid, input int rst_addr,
                           input bit exp_err, input int exp_writes);
    int exp_rd = 0, exp_wr = 0, lv_seen = 0, emitted = 0, held = 0;
    int after = 0, cyc = 0, done_cyc = -1, last_ov = -1, prev_addr = 0;
    bit pend = 0, prev_rd = 0, seen_done = 0, err_at_done = 0;
    while (!seen_done && cyc < 3000) begin
      @(negedge clk);
      reset = (rst_addr >= 0 && cyc >= 2 && exp_rd == rst_addr);
      start = (cyc == 0) || (start_mid && exp_rd == 30);
      hold  = (exp_rd == hold_addr && held < hold_len);
      if (hold) held++;
      lov = 1'b0;
      if (late) lov = (after >= 1 && after <= 10);
      else if (extra && after == 1) lov = 1'b1;
      else if (pend && emitted < n_out) begin
        lov = 1'b1;
        emitted++;
      end
      pend = 1'b0;
      lof  = (!late && after == 2);
      #1;
      if (reset) begin
        check({tag, " rst rd_en"}, rd_en, 0);
        check({tag, " rst busy"}, busy, 0);
        check({tag, " rst wr_en"}, wr_en, 0);
        check({tag, " rst layer_reset"}, layer_reset, 1);
        @(negedge clk);
        reset = 0; start = 0; hold = 0; lov = 0; lof = 0;
        #1;
        check({tag, " post-rst busy"}, busy, 0);
        check({tag, " post-rst rd_en"}, rd_en, 0);
        check({tag, " post-rst rd_addr"}, rd_addr, 0);
        check({tag, " post-rst layer_valid"}, layer_valid, 0);
        check({tag, " post-rst layer_finish"}, layer_finish, 0);
        check({tag, " post-rst layer_reset"}, layer_reset, 0);
        check({tag, " post-rst wr_en"}, wr_en, 0);
        check({tag, " post-rst done"}, done, 0);
        check({tag, " post-rst error"}, error, 0);
        sticky_err = 1'b0;
        return;
      end
      if (cyc == 0) begin
        check({tag, " idle busy"}, busy, 0);
        check({tag, " idle error"}, error, sticky_err);
      end
      if (cyc == 1) begin
        check({tag, " clear layer_reset"}, layer_reset, 1);
        check({tag, " clear busy"}, busy, 1);
      end
      if (cyc == 2) check({tag, " feed error cleared"}, error, 0);
      if (cyc >= 2) check($sformatf("%s c%0d layer_reset", tag, cyc), layer_reset, 0);
      check($sformatf("%s c%0d layer_valid", tag, cyc), layer_valid, prev_rd);
      check($sformatf("%s c%0d layer_finish", tag, cyc), layer_finish,
            (prev_rd && prev_addr == N_PIX - 1));
      if (cyc >= 2 && exp_rd < N_PIX)
        check($sformatf("%s c%0d rd_en", tag, cyc), rd_en, !hold);
      else
        check($sformatf("%s c%0d rd_en idle", tag, cyc), rd_en, 0);
      if (rd_en) begin
        check($sformatf("%s c%0d rd_addr", tag, cyc), rd_addr, exp_rd);
        exp_rd++;
      end
      if (lov) begin
        last_ov = cyc;
        if (exp_wr < N_OUT) begin
          check($sformatf("%s c%0d wr_en", tag, cyc), wr_en, 1);
          check($sformatf("%s c%0d wr_addr", tag, cyc), wr_addr, exp_wr);
          exp_wr++;
        end else begin
          check($sformatf("%s c%0d overflow wr_en", tag, cyc), wr_en, 0);
        end
      end else begin
        check($sformatf("%s c%0d wr_en quiet", tag, cyc), wr_en, 0);
      end
      if (done) begin
        seen_done   = 1'b1;
        done_cyc    = cyc;
        err_at_done = error;
      end
      prev_rd   = rd_en;
      prev_addr = rd_addr;
      if (layer_valid) begin
        lv_seen++;
        if (lv_seen % 4 == 0) pend = 1'b1;
      end
      if (after > 0) after++;
      else if (exp_rd == N_PIX) after = 1;
      cyc++;
    end
    check({tag, " done seen"}, seen_done, 1);
    check({tag, " read count"}, exp_rd, N_PIX);
    check({tag, " write count"}, exp_wr, exp_writes);
    check({tag, " error at done"}, err_at_done, exp_err);
    if (late) check({tag, " timeout distance"}, done_cyc - last_ov, TMO);
    @(negedge clk);
    start = 0; hold = 0; lov = 0; lof = 0;
    #1;
    check({tag, " done one pulse"}, done, 0);
    check({tag, " back to idle"}, busy, 0);
    sticky_err = exp_err;
  endtask

  initial begin
    reset = 1; start = 0; hold = 0; lov = 0; lof = 0;
    //            rst st hd ov of  rd ad lr lv lf wr wa bu dn er
    tbl[0]  = '{1, 0, 0, 0, 0,  0, 0, 1, 0, 0, 0, 0, 0, 0, 0};
    tbl[1]  = '{0, 1, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[2]  = '{0, 0, 0, 0, 0,  0, 0, 1, 0, 0, 0, 0, 1, 0, 0};
    tbl[3]  = '{0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0, 1, 0, 0};
    tbl[4]  = '{0, 0, 0, 0, 0,  1, 1, 0, 1, 0, 0, 0, 1, 0, 0};
    tbl[5]  = '{0, 0, 1, 0, 0,  0, 0, 0, 1, 0, 0, 0, 1, 0, 0};
    tbl[6]  = '{0, 1, 0, 0, 0,  1, 2, 0, 0, 0, 0, 0, 1, 0, 0};
    tbl[7]  = '{0, 0, 0, 1, 0,  1, 3, 0, 1, 0, 1, 0, 1, 0, 0};
    tbl[8]  = '{0, 0, 0, 1, 1,  1, 4, 0, 1, 0, 1, 1, 1, 0, 0};
    tbl[9]  = '{0, 0, 0, 0, 0,  1, 5, 0, 1, 0, 0, 0, 1, 0, 1};
    tbl[10] = '{1, 0, 0, 0, 0,  0, 0, 1, 0, 0, 0, 0, 0, 0, 0};
    tbl[11] = '{0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0};

    repeat (2) @(negedge clk);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      reset = tbl[i].rst; start = tbl[i].st; hold = tbl[i].hd;
      lov = tbl[i].ov; lof = tbl[i].of;
      #1;
      check($sformatf("v%0d rd_en", i), rd_en, tbl[i].e_rd);
      check($sformatf("v%0d rd_addr", i), rd_addr, tbl[i].e_addr);
      check($sformatf("v%0d layer_reset", i), layer_reset, tbl[i].e_lr);
      check($sformatf("v%0d layer_valid", i), layer_valid, tbl[i].e_lv);
      check($sformatf("v%0d layer_finish", i), layer_finish, tbl[i].e_lf);
      check($sformatf("v%0d wr_en", i), wr_en, tbl[i].e_wr);
      check($sformatf("v%0d wr_addr", i), wr_addr, tbl[i].e_waddr);
      check($sformatf("v%0d busy", i), busy, tbl[i].e_busy);
      check($sformatf("v%0d done", i), done, tbl[i].e_done);
      check($sformatf("v%0d error", i), error, tbl[i].e_err);
    end
    reset = 0;
    sticky_err = 1'b0;

    //        tag        n_out hold_at len late extra smid rst  err writes
    run_frame("normal",  25,   -1,     0,  0,   0,    0,   -1,  0,  25);
    run_frame("hold40",  25,   40,     3,  0,   0,    0,   -1,  0,  25);
    run_frame("short24", 24,   -1,     0,  0,   0,    0,   -1,  1,  24);
    run_frame("timeout", 0,    -1,     0,  1,   0,    0,   -1,  1,  10);
    run_frame("over26",  25,   -1,     0,  0,   1,    1,   -1,  1,  25);
    run_frame("rst57",   25,   -1,     0,  0,   0,    0,   57,  0,  25);
    run_frame("restart", 25,   -1,     0,  0,   0,    0,   -1,  0,  25);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sampling_layer2_controller.md
SAMPLING_LAYER2_CONTROLLER -- requirements
Module: sampling_layer2_controller

Interface
REQ-001 Parameters SHALL be: IMG_W, default 10, input feature-map width; IMG_H, default 10, input feature-map height; TIMEOUT, default 255, maximum idle drain cycles.
REQ-002 Clock  input  1  sole clock; all logic SHALL be on the rising edge.
REQ-003 Input_Reset  input  1  synchronous, active-high reset.
REQ-004 Start  input  1  single-cycle request to process one 6-channel feature map.
REQ-005 Hold  input  1  stalls issuing of read addresses while high.
REQ-006 Rd_En, Rd_Addr  output  1, 7  input-buffer read strobe and raster address (0..IMG_W*IMG_H-1); buffer read latency is 1 cycle.
REQ-007 Layer_Reset, Layer_Valid, Layer_Finish  output  1 each  drive the sampling layer's Input_Reset, Input_Valid and Input_Finish.
REQ-008 Layer_Out_Valid, Layer_Out_Finish  input  1 each  the sampling layer's Output_Valid and Output_Finish.
REQ-009 Wr_En, Wr_Addr  output  1, 5  output-buffer write strobe and address (0..(IMG_W/2)*(IMG_H/2)-1).
REQ-010 Busy, Done, Error  output  1 each  Busy high outside IDLE; Done is a 1-cycle completion pulse; Error is a sticky fault flag.

Function
REQ-011 The FSM SHALL have the states IDLE, CLEAR, FEED, DRAIN and DONE.
REQ-012 IDLE->CLEAR when Start=1; Start SHALL be ignored in every other state.
REQ-013 CLEAR SHALL last exactly 1 cycle, assert Layer_Reset=1, zero the read and write counters, and clear Error; it then goes to FEED.
REQ-014 In FEED, on each cycle with Hold=0, the block SHALL assert Rd_En=1 with Rd_Addr=read count and then increment the count; with Hold=1, Rd_En=0 and the count SHALL hold.
REQ-015 Layer_Valid SHALL equal Rd_En delayed by exactly 1 cycle, so the layer sees the pixels in row-major order.
REQ-016 Layer_Finish SHALL be asserted in the same cycle as the Layer_Valid for address IMG_W*IMG_H-1, and only then.
REQ-017 FEED->DRAIN SHALL occur in the cycle after the last address is issued.
REQ-018 In FEED and DRAIN, each Layer_Out_Valid=1 SHALL produce Wr_En=1 in the same cycle with Wr_Addr=write count; the write count then increments.
REQ-019 A Layer_Out_Valid arriving when the write count already equals (IMG_W/2)*(IMG_H/2) SHALL suppress Wr_En and set Error.
REQ-020 DRAIN->DONE SHALL occur on Layer_Out_Finish=1; if the write count after that cycle's write is not (IMG_W/2)*(IMG_H/2), Error SHALL be set.
REQ-021 DRAIN SHALL count consecutive cycles without Layer_Out_Valid; on reaching TIMEOUT it SHALL set Error and go to DONE.
REQ-022 DONE SHALL assert Done=1 for 1 cycle and return to IDLE; Busy=0 in IDLE only.
REQ-023 Error SHALL persist until the next CLEAR or reset.
REQ-024 Layer_Out_Finish received in FEED SHALL set Error without leaving FEED.
REQ-025 A 1-cycle Layer_Valid gap SHALL follow every Hold cycle; the layer is required to tolerate non-contiguous valids.

Reset
REQ-026 Input_Reset=1 SHALL force IDLE in any state, including mid-FEED or mid-DRAIN.
REQ-027 Input_Reset=1 SHALL zero all counters and the valid delay stage, and SHALL set every output to 0 except Layer_Reset, which SHALL be driven 1 while Input_Reset is high.

Structure
REQ-028 The IMG_W/IMG_H defaults, output count, address widths, TIMEOUT and the state encoding SHALL live in the shared package sampling_ctrl_pkg.
REQ-029 The controller SHALL be a single module with no sub-module; pixel data SHALL bypass it and be wired at the top level from the input buffer to the layer.

Verification
REQ-030 Start, Hold=0, and a layer model producing 25 outputs plus Finish -> 100 Rd_En cycles with addresses 0..99, Layer_Finish with the 100th Layer_Valid, Wr_Addr 0..24, one Done pulse, Error=0.
REQ-031 Hold high for 3 cycles at address 40 -> no Rd_En for those 3 cycles, the next read is address 40, and the remainder of the run is unchanged.
REQ-032 Layer model emits only 24 outputs, then Finish -> Done pulse with Error=1.
REQ-033 Layer model is silent after 10 outputs -> Error=1 and Done exactly TIMEOUT cycles after the last Out_Valid.
REQ-034 Input_Reset asserted at address 57 -> IDLE the next cycle, all outputs 0; a following Start restarts from address 0 with Layer_Reset pulsed.
REQ-035 Start pulsed during FEED, and a 26th Out_Valid -> Start ignored; the 26th output is not written and Error=1.
